// File: rtl/bcd_2dig_to_bin_pkg.sv
// bcd_2dig_to_bin_pkg: shared FSM encodings, constants and digit check for the BCD-to-binary converter
package bcd_2dig_to_bin_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
   localparam logic [3:0] DD_ITER = 4'd8;
   function automatic logic digits_ok(input logic [3:0] d1, input logic [3:0] d0);
      return (d1 <= BCD_DIGIT_MAX) && (d0 <= BCD_DIGIT_MAX);
   endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble nibble correction, subtracts 3 from nibbles of 8 or more
module bcd_digit_adj (
   input  logic [3:0] nib_in,
   output logic [3:0] nib_out
);
   assign nib_out = (nib_in >= 4'd8) ? nib_in - 4'd3 : nib_in;
endmodule

// File: rtl/bcd_2dig_to_bin.sv
// bcd_2dig_to_bin: 2-digit BCD to binary converter with range check; define BCD_CLAMP_EN to clamp out-of-range values to MAX_VAL
module bcd_2dig_to_bin
   import bcd_2dig_to_bin_pkg::*;
#(
   parameter int W       = 7,
   parameter int MAX_VAL = 59
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [3:0]   digit1,
   input  logic [3:0]   digit0,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [W-1:0] bin_out
);
   localparam logic [7:0] MAX8 = 8'(MAX_VAL);
   state_t      state;
   logic [15:0] sr;
   logic [15:0] sr_sh;
   logic [15:0] sr_nx;
   logic [3:0]  cnt;
   logic        bad;
   logic [3:0]  hi_adj;
   logic [3:0]  lo_adj;
   logic [7:0]  val;
   logic        over;
   logic [W-1:0] bin_nx;
   logic        err_nx;

   assign sr_sh = sr >> 1;

   bcd_digit_adj u_adj_hi (.nib_in(sr_sh[15:12]), .nib_out(hi_adj));
   bcd_digit_adj u_adj_lo (.nib_in(sr_sh[11:8]),  .nib_out(lo_adj));

   assign sr_nx = {hi_adj, lo_adj, sr_sh[7:0]};
   assign val   = sr[7:0];
   assign over  = val > MAX8;

   // result selection: invalid digits force zero, out-of-range either clamps or passes through
   always_comb begin
`ifdef BCD_CLAMP_EN
      bin_nx = bad ? '0 : over ? W'(MAX8) : W'(val);
`else
      bin_nx = bad ? '0 : W'(val);
`endif
      err_nx = bad | over;
   end

   // control FSM: accept, eight shift/adjust iterations, then register the result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sr      <= '0;
         cnt     <= '0;
         bad     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         bin_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sr    <= {digit1, digit0, 8'h00};
                  cnt   <= '0;
                  bad   <= !digits_ok(digit1, digit0);
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sr  <= sr_nx;
               cnt <= cnt + 4'd1;
               if (cnt == DD_ITER - 4'd1) state <= DONE;
            end
            DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               bin_out <= bin_nx;
               err     <= err_nx;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
